// File: rtl/clk_step_monitor.sv
// Observes the CPU step strobe and hold level on the raw board clock. Reports the step count,
// the step period, accumulated hold time, an activity state, and a switch-selected LED word.
module clk_step_monitor #(
  parameter int CNT_W   = 32,
  parameter int HOLD_W  = 16,
  parameter int TIMEOUT = 1000000
) (
  input  logic              raw_clk,
  input  logic              rst,
  input  logic              step,
  input  logic              hold,
  input  logic              clear,
  input  logic [1:0]        disp_sel,
  output logic [CNT_W-1:0]  step_cnt,
  output logic [CNT_W-1:0]  period,
  output logic [HOLD_W-1:0] hold_cnt,
  output logic [1:0]        state,
  output logic              period_vld,
  output logic [15:0]       led
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HELD  = 2'd2,
    STALL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(TIMEOUT - 1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   gap;
  logic               step_seen;
  logic               leave_held;
  logic [15:0]        led_d;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [HOLD_W-1:0] sat_inc_hold(input logic [HOLD_W-1:0] v);
    return (&v) ? v : v + HOLD_W'(1);
  endfunction

  assign leave_held = (state_q == HELD) && !hold;
  assign state      = state_q;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (hold) begin
      state_d = HELD;
    end else if (step) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (gap >= GAP_LIM) state_d = STALL;
        HELD:    state_d = step_seen ? RUN : IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    led_d = '0;
    case (disp_sel)
      2'd0:    led_d = 16'(step_cnt);
      2'd1:    led_d = 16'(period);
      2'd2:    led_d = 16'(hold_cnt);
      default: led_d = {state_q, period_vld, hold, 4'h0, step_cnt[7:0]};
    endcase
  end

  always_ff @(posedge raw_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge raw_clk or negedge rst) begin
    if (!rst) begin
      step_cnt   <= '0;
      period     <= '0;
      hold_cnt   <= '0;
      gap        <= '0;
      period_vld <= 1'b0;
      step_seen  <= 1'b0;
      led        <= '0;
    end else begin
      // led samples last cycle's sources, so a clear shows up on it one cycle later
      led <= led_d;
      if (clear) begin
        step_cnt   <= '0;
        period     <= '0;
        hold_cnt   <= '0;
        gap        <= '0;
        period_vld <= 1'b0;
        step_seen  <= 1'b0;
      end else begin
        if (step) begin
          step_cnt  <= step_cnt + CNT_W'(1);
          step_seen <= 1'b1;
          if (step_seen) begin
            period     <= sat_inc_cnt(gap);
            period_vld <= 1'b1;
          end
        end
        if (hold) begin
          hold_cnt <= sat_inc_hold(hold_cnt);
        end
        // held time is frozen out of the gap so a long hold never looks like a stall
        if (step || leave_held) begin
          gap <= '0;
        end else if (!hold) begin
          gap <= sat_inc_cnt(gap);
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_step_monitor.sv
// Directed bench for clk_step_monitor: expectations are queued as each step is driven and
// checked against the DUT outputs after the clock edge that produces them.
module tb_clk_step_monitor;

  logic        raw_clk;
  logic        rst;
  logic        step;
  logic        hold;
  logic        clear;
  logic [1:0]  disp_sel;
  logic [31:0] step_cnt;
  logic [31:0] period;
  logic [15:0] hold_cnt;
  logic [1:0]  state;
  logic        period_vld;
  logic [15:0] led;

  logic [31:0] step_cnt4;
  logic [31:0] period4;
  logic [3:0]  hold_cnt4;
  logic [1:0]  state4;
  logic        period_vld4;
  logic [15:0] led4;

  int vectors;
  int miscompares;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  clk_step_monitor #(.CNT_W(32), .HOLD_W(16), .TIMEOUT(16)) dut (
    .raw_clk(raw_clk), .rst(rst), .step(step), .hold(hold), .clear(clear),
    .disp_sel(disp_sel), .step_cnt(step_cnt), .period(period), .hold_cnt(hold_cnt),
    .state(state), .period_vld(period_vld), .led(led)
  );

  clk_step_monitor #(.CNT_W(32), .HOLD_W(4), .TIMEOUT(16)) dut4 (
    .raw_clk(raw_clk), .rst(rst), .step(step), .hold(hold), .clear(clear),
    .disp_sel(disp_sel), .step_cnt(step_cnt4), .period(period4), .hold_cnt(hold_cnt4),
    .state(state4), .period_vld(period_vld4), .led(led4)
  );

  initial raw_clk = 1'b0;
  always #5 raw_clk = ~raw_clk;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:       return step_cnt;
      1:       return period;
      2:       return {16'h0, hold_cnt};
      3:       return {30'h0, state};
      4:       return {31'h0, period_vld};
      5:       return {16'h0, led};
      default: return {28'h0, hold_cnt4};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic push_core(input string tag, input logic [31:0] sc, input logic [31:0] per,
                           input logic vld, input logic [1:0] st);
    push({tag, ".step_cnt"}, 0, sc);
    push({tag, ".period"}, 1, per);
    push({tag, ".period_vld"}, 4, {31'h0, vld});
    push({tag, ".state"}, 3, {30'h0, st});
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      vectors++;
      assert (o === e.exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic cyc(input logic s, input logic h, input logic c);
    step  = s;
    hold  = h;
    clear = c;
    @(posedge raw_clk);
    #1;
    step  = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b0;
    step     = 1'b0;
    hold     = 1'b0;
    clear    = 1'b0;
    disp_sel = 2'd0;
    repeat (2) @(posedge raw_clk);
    #1;
    push_core("rst0", 0, 0, 1'b0, 2'd0);
    push("rst0.hold_cnt", 2, 0);
    push("rst0.led", 5, 0);
    drain();
    rst = 1'b1;

    // five steps, eight cycles apart
    for (int n = 1; n <= 5; n++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (n == 1) begin
        push_core("single", 1, 0, 1'b0, 2'd1);
        drain();
      end
      if (n < 5) repeat (7) cyc(1'b0, 1'b0, 1'b0);
    end
    push_core("five", 5, 8, 1'b1, 2'd1);
    drain();

    cyc(1'b0, 1'b0, 1'b0);
    push("led.cnt", 5, 32'd5);
    drain();
    disp_sel = 2'd1;
    cyc(1'b0, 1'b0, 1'b0);
    push("led.period", 5, 32'd8);
    drain();
    disp_sel = 2'd3;
    cyc(1'b0, 1'b0, 1'b0);
    push("led.status", 5, 32'h6005);
    drain();
    disp_sel = 2'd2;
    cyc(1'b0, 1'b0, 1'b0);
    push("led.hold", 5, 32'd0);
    drain();

    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    push_core("b2b", 7, 1, 1'b1, 2'd1);
    drain();

    // stall boundary: RUN through the 15th silent cycle, STALL on the 16th
    repeat (15) cyc(1'b0, 1'b0, 1'b0);
    push("pre_stall.state", 3, 32'd1);
    drain();
    cyc(1'b0, 1'b0, 1'b0);
    push("stall.state", 3, 32'd3);
    drain();
    cyc(1'b1, 1'b0, 1'b0);
    push_core("unstall", 8, 17, 1'b1, 2'd1);
    drain();

    repeat (20) cyc(1'b0, 1'b1, 1'b0);
    push("held.state", 3, 32'd2);
    push("held.hold_cnt", 2, 32'd20);
    push("held.hold_cnt4", 6, 32'd15);
    drain();
    cyc(1'b0, 1'b0, 1'b0);
    push("release.state", 3, 32'd1);
    push("release.hold_cnt", 2, 32'd20);
    drain();
    repeat (15) cyc(1'b0, 1'b0, 1'b0);
    push("post_hold.state", 3, 32'd1);
    drain();
    cyc(1'b0, 1'b0, 1'b0);
    push("post_hold_stall.state", 3, 32'd3);
    drain();

    cyc(1'b0, 1'b0, 1'b1);
    push_core("clear", 0, 0, 1'b0, 2'd0);
    push("clear.hold_cnt", 2, 32'd0);
    push("clear.hold_cnt4", 6, 32'd0);
    drain();
    repeat (40) cyc(1'b0, 1'b1, 1'b0);
    push("hold40.hold_cnt", 2, 32'd40);
    push("hold40.hold_cnt4", 6, 32'd15);
    push("hold40.state", 3, 32'd2);
    drain();
    cyc(1'b0, 1'b0, 1'b0);
    push("hold40_rel.state", 3, 32'd0);
    drain();

    cyc(1'b1, 1'b0, 1'b0);
    push("pre_clr.step_cnt", 0, 32'd1);
    push("pre_clr.state", 3, 32'd1);
    drain();
    cyc(1'b1, 1'b0, 1'b1);
    push_core("clr_step", 0, 0, 1'b0, 2'd0);
    drain();

    cyc(1'b1, 1'b1, 1'b0);
    push("step_hold.step_cnt", 0, 32'd1);
    push("step_hold.state", 3, 32'd2);
    push("step_hold.hold_cnt", 2, 32'd1);
    drain();
    cyc(1'b0, 1'b0, 1'b0);
    push("step_hold_rel.state", 3, 32'd1);
    drain();

    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    push_core("pre_rst", 3, 1, 1'b1, 2'd1);
    drain();
    #3;
    rst = 1'b0;
    #1;
    push_core("async_rst", 0, 0, 1'b0, 2'd0);
    push("async_rst.hold_cnt", 2, 32'd0);
    push("async_rst.led", 5, 32'd0);
    push("async_rst.hold_cnt4", 6, 32'd0);
    drain();
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
